// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage : IF stage of the 5-stage RV32I pipeline.
//
// Holds the fetch PC, drives the instruction-memory address and captures the
// fetched instruction into the IF/ID pipeline register.
//
// Ports
//   clk          clock, all state updates on rising edge
//   rst          asynchronous reset, active-low
//   stall_f      hold the PC register
//   stall_d      hold the IF/ID register
//   flush_d      replace IF/ID contents with a bubble (wins over stall_d)
//   pc_src_e     redirect fetch to pc_target_e (wins over stall_f)
//   pc_target_e  branch/jump target from EX
//   imem_rdata   instruction at imem_addr (combinational read)
//   imem_addr    instruction-memory address, identical to pc_f
//   pc_f         current fetch PC
//   instr_d      IF/ID instruction
//   pc_d         IF/ID PC
//   pc_plus4_d   IF/ID PC+4
//   valid_d      IF/ID holds a real fetched instruction
// ---------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_f,
   input  logic        stall_d,
   input  logic        flush_d,
   input  logic        pc_src_e,
   input  logic [31:0] pc_target_e,
   input  logic [31:0] imem_rdata,
   output logic [31:0] imem_addr,
   output logic [31:0] pc_f,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc_plus4_d,
   output logic        valid_d
);

   logic [31:0] pcf_q, pcf_d;
   logic [31:0] pc_plus4_f;

   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_pc_q,    ifid_pc_d;
   logic [31:0] ifid_pc4_q,   ifid_pc4_d;
   logic        ifid_valid_q, ifid_valid_d;

   // Wraps modulo 2^32; the carry out is deliberately dropped.
   assign pc_plus4_f = pcf_q + 32'd4;

   always_comb begin
      pcf_d = pc_plus4_f;
      if (pc_src_e) begin
         // Targets are forced word-aligned; low two bits are ignored.
         pcf_d = {pc_target_e[31:2], 2'b00};
      end else if (stall_f) begin
         pcf_d = pcf_q;
      end
   end

   always_comb begin
      ifid_instr_d = imem_rdata;
      ifid_pc_d    = pcf_q;
      ifid_pc4_d   = pc_plus4_f;
      ifid_valid_d = 1'b1;
      if (flush_d) begin
         ifid_instr_d = NOP_INSTR;
         ifid_pc_d    = 32'd0;
         ifid_pc4_d   = 32'd0;
         ifid_valid_d = 1'b0;
      end else if (stall_d) begin
         ifid_instr_d = ifid_instr_q;
         ifid_pc_d    = ifid_pc_q;
         ifid_pc4_d   = ifid_pc4_q;
         ifid_valid_d = ifid_valid_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pcf_q        <= RESET_PC;
         ifid_instr_q <= NOP_INSTR;
         ifid_pc_q    <= 32'd0;
         ifid_pc4_q   <= 32'd0;
         ifid_valid_q <= 1'b0;
      end else begin
         pcf_q        <= pcf_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   assign pc_f       = pcf_q;
   assign imem_addr  = pcf_q;
   assign instr_d    = ifid_instr_q;
   assign pc_d       = ifid_pc_q;
   assign pc_plus4_d = ifid_pc4_q;
   assign valid_d    = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage : directed scenarios plus randomized traffic against a
// behavioural model of the IF stage.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        stall_f;
   logic        stall_d;
   logic        flush_d;
   logic        pc_src_e;
   logic [31:0] pc_target_e;
   logic [31:0] imem_rdata;
   logic [31:0] imem_addr;
   logic [31:0] pc_f;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4_d;
   logic        valid_d;

   int n_cmp;
   int n_err;

   // model state
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_pcd;
   logic [31:0] m_pc4d;
   logic        m_valid;

   fetch_stage #(
      .RESET_PC  (RESET_PC),
      .NOP_INSTR (NOP_INSTR)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .stall_f     (stall_f),
      .stall_d     (stall_d),
      .flush_d     (flush_d),
      .pc_src_e    (pc_src_e),
      .pc_target_e (pc_target_e),
      .imem_rdata  (imem_rdata),
      .imem_addr   (imem_addr),
      .pc_f        (pc_f),
      .instr_d     (instr_d),
      .pc_d        (pc_d),
      .pc_plus4_d  (pc_plus4_d),
      .valid_d     (valid_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] imem_fn(input logic [31:0] addr);
      if (addr == 32'd0) return 32'h00A0_0093;
      return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   assign imem_rdata = imem_fn(imem_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc    = RESET_PC;
      m_instr = NOP_INSTR;
      m_pcd   = 32'd0;
      m_pc4d  = 32'd0;
      m_valid = 1'b0;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".pc_f"},       pc_f,       m_pc);
      check({tag, ".imem_addr"},  imem_addr,  m_pc);
      check({tag, ".instr_d"},    instr_d,    m_instr);
      check({tag, ".pc_d"},       pc_d,       m_pcd);
      check({tag, ".pc_plus4_d"}, pc_plus4_d, m_pc4d);
      check({tag, ".valid_d"},    {31'd0, valid_d}, {31'd0, m_valid});
   endtask

   // One clock: predict from the inputs held across the edge, then compare
   // 1 time unit after the edge.
   task automatic cycle(input string tag);
      logic [31:0] n_pc, n_instr, n_pcd, n_pc4d;
      logic        n_valid;
      if (pc_src_e)     n_pc = pc_target_e & 32'hFFFF_FFFC;
      else if (stall_f) n_pc = m_pc;
      else              n_pc = m_pc + 32'd4;
      if (flush_d) begin
         n_instr = NOP_INSTR; n_pcd = 0; n_pc4d = 0; n_valid = 0;
      end else if (stall_d) begin
         n_instr = m_instr; n_pcd = m_pcd; n_pc4d = m_pc4d; n_valid = m_valid;
      end else begin
         n_instr = imem_fn(m_pc); n_pcd = m_pc; n_pc4d = m_pc + 32'd4; n_valid = 1;
      end
      @(posedge clk);
      #1;
      m_pc = n_pc; m_instr = n_instr; m_pcd = n_pcd; m_pc4d = n_pc4d; m_valid = n_valid;
      check_model(tag);
   endtask

   task automatic idle_inputs();
      stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0; pc_target_e = 0;
   endtask

   task automatic redirect(input logic [31:0] tgt, input string tag);
      pc_src_e = 1; pc_target_e = tgt; flush_d = 1;
      cycle(tag);
      idle_inputs();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      idle_inputs();
      rst = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst.pc_f",    pc_f,    RESET_PC);
      check("rst.instr_d", instr_d, NOP_INSTR);
      check("rst.pc_d",    pc_d,    32'd0);
      check("rst.pc4_d",   pc_plus4_d, 32'd0);
      check("rst.valid_d", {31'd0, valid_d}, 32'd0);
      @(negedge clk);
      rst = 1;

      // free run from reset
      cycle("run1");
      check("run1.pc_f",    pc_f,    32'h4);
      check("run1.instr_d", instr_d, 32'h00A0_0093);
      check("run1.pc_d",    pc_d,    32'h0);
      check("run1.pc4_d",   pc_plus4_d, 32'h4);
      check("run1.valid_d", {31'd0, valid_d}, 32'd1);
      cycle("run2");
      check("run2.pc_f", pc_f, 32'h8);
      cycle("run3");
      check("run3.pc_f", pc_f, 32'hC);
      cycle("run4");
      check("run4.pc_f", pc_f, 32'h10);

      // taken branch with flush
      redirect(32'h40, "redir");
      check("redir.pc_f",    pc_f,    32'h40);
      check("redir.instr_d", instr_d, NOP_INSTR);
      check("redir.valid_d", {31'd0, valid_d}, 32'd0);
      cycle("redir2");
      check("redir2.pc_d", pc_d, 32'h40);

      // load-use stall at pc_f=0x20, pc_d=0x1C
      redirect(32'h1C, "lu_setup");
      cycle("lu_setup2");
      check("lu.pre_pc_f", pc_f, 32'h20);
      check("lu.pre_pc_d", pc_d, 32'h1C);
      stall_f = 1; stall_d = 1;
      for (int i = 0; i < 2; i++) begin
         cycle("lu_stall");
         check("lu.hold_pc_f", pc_f, 32'h20);
         check("lu.hold_pc_d", pc_d, 32'h1C);
      end
      idle_inputs();
      cycle("lu_rel");
      check("lu.rel_pc_f", pc_f, 32'h24);
      check("lu.rel_pc_d", pc_d, 32'h20);

      // flush wins over stall_d
      stall_d = 1; flush_d = 1;
      cycle("flstall");
      check("flstall.valid_d", {31'd0, valid_d}, 32'd0);
      check("flstall.instr_d", instr_d, NOP_INSTR);
      idle_inputs();

      // redirect wins over stall_f, misaligned target
      pc_src_e = 1; pc_target_e = 32'h103; stall_f = 1; flush_d = 1;
      cycle("misalign");
      check("misalign.pc_f", pc_f, 32'h100);
      idle_inputs();

      // wrap at top of address space
      redirect(32'hFFFF_FFFC, "wrap_setup");
      cycle("wrap");
      check("wrap.pc_f",  pc_f,       32'h0);
      check("wrap.pc_d",  pc_d,       32'hFFFF_FFFC);
      check("wrap.pc4_d", pc_plus4_d, 32'h0);

      // asynchronous reset between edges
      cycle("pre_ar");
      #2;
      pc_src_e = 1; pc_target_e = 32'h500; stall_f = 1;
      rst = 0;
      #1;
      model_reset();
      check("arst.pc_f",    pc_f,    RESET_PC);
      check("arst.valid_d", {31'd0, valid_d}, 32'd0);
      check_model("arst");
      @(negedge clk);
      idle_inputs();
      rst = 1;
      cycle("post_ar");

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         pc_src_e    = ($urandom_range(0, 7) == 0);
         flush_d     = pc_src_e | ($urandom_range(0, 15) == 0);
         stall_f     = ($urandom_range(0, 4) == 0);
         stall_d     = stall_f ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 15) == 0);
         pc_target_e = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : $urandom;
         cycle("rnd");
      end
      idle_inputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
